// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared widths, FSM state enum and owner helper for the SDRAM arbiter
package sdram_pkg;

  localparam int AW_DEF = 24;  // SDRAM word address width
  localparam int DW_DEF = 16;  // data beat width
  localparam int LW_DEF = 4;   // burst length field width, beats = len + 1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  // Requester index to one-hot grant/handshake vector.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_arbiter_pick.sv
// rtl/sdram_arbiter_pick.sv - two-input winner selector for the SDRAM arbiter
//
// Purpose: combinational choice between the display reader (0) and the
// capture writer (1). A lone requester always wins; on a tie the requester
// that was not granted last wins. Fixed priority is obtained by tying
// last_i high, which makes requester 0 win every tie.
//
// Ports:
//   valid_i  [1:0]  per-requester command valid
//   last_i          index of the requester granted most recently
//   any_o           at least one requester is valid
//   winner_o        index of the selected requester (0 when none valid)
module arb_pick (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o    = |valid_i;
  assign winner_o = (valid_i == 2'b11) ? ~last_i : valid_i[1];

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-requester burst arbiter in front of an SDRAM controller
//
// Purpose: grants one of two requesters (0 = display reader, 1 = capture
// writer) the SDRAM controller for a whole burst. The winning command is
// latched in IDLE, offered to the controller in CMD, and the data beats are
// passed through in WDATA or RDATA until len+1 beats have moved.
//
// Configuration macro: SDRAM_ARB_RR_EN
//   defined   - round-robin on ties (requester not granted last wins)
//   undefined - fixed priority, requester 0 wins ties
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester command handshake (ready one-hot)
//   req_addr/req_we/req_len  per-requester command fields
//   req_wdata/req_wready     per-requester write beat handshake
//   req_rdata/req_rvalid     read beat, rvalid one-hot to the owner
//   m_valid/m_ready          command handshake to the controller
//   m_addr/m_we/m_len        latched command fields
//   m_wdata/m_wready         write beat to the controller
//   m_rdata/m_rvalid         read beat from the controller
//   gnt                      one-hot current owner, 0 when idle
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][AW-1:0]   req_addr,
  input  logic [1:0]           req_we,
  input  logic [1:0][LW-1:0]   req_len,
  input  logic [1:0][DW-1:0]   req_wdata,
  output logic [1:0]           req_wready,
  output logic [DW-1:0]        req_rdata,
  output logic [1:0]           req_rvalid,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AW-1:0]        m_addr,
  output logic                 m_we,
  output logic [LW-1:0]        m_len,
  output logic [DW-1:0]        m_wdata,
  input  logic                 m_wready,
  input  logic [DW-1:0]        m_rdata,
  input  logic                 m_rvalid,
  output logic [1:0]           gnt
);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [LW-1:0]    cnt_q,   cnt_d;
  logic [AW-1:0]    addr_q,  addr_d;
  logic             we_q,    we_d;
  logic [LW-1:0]    len_q,   len_d;

  logic             pick_any;
  logic             pick_win;
  logic             pick_last;

`ifdef SDRAM_ARB_RR_EN
  logic             last_q, last_d;
  assign pick_last = last_q;
`else
  // Pretending requester 1 always won last makes requester 0 win every tie.
  assign pick_last = 1'b1;
`endif

  arb_pick u_pick (
    .valid_i  (req_valid),
    .last_i   (pick_last),
    .any_o    (pick_any),
    .winner_o (pick_win)
  );

  assign m_addr    = addr_q;
  assign m_we      = we_q;
  assign m_len     = len_q;
  assign m_wdata   = req_wdata[owner_q];
  assign req_rdata = m_rdata;
  assign gnt       = (state_q == IDLE) ? 2'b00 : owner_onehot(owner_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    len_d      = len_q;
`ifdef SDRAM_ARB_RR_EN
    last_d     = last_q;
`endif
    m_valid    = 1'b0;
    req_ready  = 2'b00;
    req_wready = 2'b00;
    req_rvalid = 2'b00;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_win;
          addr_d  = req_addr[pick_win];
          we_d    = req_we[pick_win];
          len_d   = req_len[pick_win];
          state_d = CMD;
`ifdef SDRAM_ARB_RR_EN
          last_d  = pick_win;
`endif
        end
      end

      CMD: begin
        // The latched command is issued even if the requester drops valid.
        m_valid = 1'b1;
        if (m_ready) begin
          req_ready = owner_onehot(owner_q);
          cnt_d     = len_q;
          state_d   = we_q ? WDATA : RDATA;
        end
      end

      WDATA: begin
        if (m_wready) begin
          req_wready = owner_onehot(owner_q);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end

      RDATA: begin
        if (m_rvalid) begin
          req_rvalid = owner_onehot(owner_q);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
`ifdef SDRAM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      len_q   <= len_d;
`ifdef SDRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter with a burst-level reference model
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0]          req_we;
  logic [1:0][LW-1:0]  req_len;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          req_wready;
  logic [DW-1:0]       req_rdata;
  logic [1:0]          req_rvalid;
  logic                m_valid;
  logic                m_ready;
  logic [AW-1:0]       m_addr;
  logic                m_we;
  logic [LW-1:0]       m_len;
  logic [DW-1:0]       m_wdata;
  logic                m_wready;
  logic [DW-1:0]       m_rdata;
  logic                m_rvalid;
  logic [1:0]          gnt;

  always #5 clk = ~clk;

  sdram_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .req_wready (req_wready),
    .req_rdata  (req_rdata),
    .req_rvalid (req_rvalid),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_we       (m_we),
    .m_len      (m_len),
    .m_wdata    (m_wdata),
    .m_wready   (m_wready),
    .m_rdata    (m_rdata),
    .m_rvalid   (m_rvalid),
    .gnt        (gnt)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [LW-1:0] len;
  } cmd_t;

  int checks = 0;
  int errors = 0;

  // Burst-level model: is a burst owned, has its command been taken, how
  // many beats remain, and who won last.
  bit   busy = 0;
  bit   acc = 0;
  int   owner = 0;
  cmd_t cur;
  int   beats = 0;
  int   last_w = 1;

  cmd_t cq0[$];
  cmd_t cq1[$];
  logic [DW-1:0] rd_log0[$];
  logic [DW-1:0] rd_seq[$];
  int   grant_log[$];
  int   wr_beats[2];
  int   rd_beats[2];
  int   ready_pulses = 0;
  int   rvalid0_cycles = 0;
  int   wready1_cycles = 0;

  int   mready_pct = 100;
  int   wready_pct = 100;
  int   rvalid_pct = 100;
  bit   rst_drive = 1;
  bit   drop_ok = 0;

  bit             s_rst;
  logic [1:0]     s_valid;
  bit             s_mready;
  bit             s_wready;
  bit             s_rvalid;
  logic [DW-1:0]  s_rdata;
  logic [1:0][DW-1:0] s_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef SDRAM_ARB_RR_EN
    return (last_w == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] oh(input int o);
    return (o == 1) ? 2'b10 : 2'b01;
  endfunction

  // Apply the effect of the clock edge that just sampled the s_* inputs.
  task automatic model_step();
    if (s_rst) begin
      busy = 0;
      acc = 0;
      last_w = 1;
      return;
    end
    if (!busy) begin
      if (s_valid != 2'b00) begin
        owner = pick(s_valid);
        cur = (owner == 0) ? cq0[0] : cq1[0];
        busy = 1;
        acc = 0;
        last_w = owner;
        grant_log.push_back(owner);
      end
    end else if (!acc) begin
      if (s_mready) begin
        acc = 1;
        beats = int'(cur.len) + 1;
        if (owner == 0) void'(cq0.pop_front());
        else            void'(cq1.pop_front());
      end
    end else begin
      if (cur.we && s_wready) begin
        wr_beats[owner]++;
        beats--;
      end else if (!cur.we && s_rvalid) begin
        rd_beats[owner]++;
        if (owner == 0) rd_log0.push_back(s_rdata);
        if (rd_seq.size() > 0) void'(rd_seq.pop_front());
        beats--;
      end
      if (beats == 0) busy = 0;
    end
  endtask

  task automatic drive();
    bit drop0, drop1;
    drop0 = drop_ok && busy && !acc && owner == 0 && ($urandom_range(0, 1) == 1);
    drop1 = drop_ok && busy && !acc && owner == 1 && ($urandom_range(0, 1) == 1);
    rst = rst_drive;
    req_valid[0] = (cq0.size() > 0) && !drop0;
    req_valid[1] = (cq1.size() > 0) && !drop1;
    req_addr[0] = (cq0.size() > 0) ? cq0[0].addr : '0;
    req_we[0]   = (cq0.size() > 0) ? cq0[0].we   : 1'b0;
    req_len[0]  = (cq0.size() > 0) ? cq0[0].len  : '0;
    req_addr[1] = (cq1.size() > 0) ? cq1[0].addr : '0;
    req_we[1]   = (cq1.size() > 0) ? cq1[0].we   : 1'b0;
    req_len[1]  = (cq1.size() > 0) ? cq1[0].len  : '0;
    req_wdata[0] = DW'($urandom);
    req_wdata[1] = DW'($urandom);
    m_ready  = ($urandom_range(0, 99) < mready_pct);
    m_wready = ($urandom_range(0, 99) < wready_pct);
    m_rvalid = ($urandom_range(0, 99) < rvalid_pct);
    m_rdata  = (rd_seq.size() > 0) ? rd_seq[0] : DW'($urandom);
    s_rst = rst;
    s_valid = req_valid;
    s_mready = m_ready;
    s_wready = m_wready;
    s_rvalid = m_rvalid;
    s_rdata = m_rdata;
    s_wdata = req_wdata;
  endtask

  task automatic check_outputs();
    logic [1:0] e_gnt, e_ready, e_wready, e_rvalid;
    e_gnt    = busy ? oh(owner) : 2'b00;
    e_ready  = (busy && !acc && s_mready) ? oh(owner) : 2'b00;
    e_wready = (busy && acc && cur.we && s_wready) ? oh(owner) : 2'b00;
    e_rvalid = (busy && acc && !cur.we && s_rvalid) ? oh(owner) : 2'b00;
    chk("gnt", gnt, e_gnt);
    chk("m_valid", m_valid, busy && !acc);
    if (busy && !acc) begin
      chk("m_addr", m_addr, cur.addr);
      chk("m_we", m_we, cur.we);
      chk("m_len", m_len, cur.len);
    end
    chk("req_ready", req_ready, e_ready);
    chk("req_wready", req_wready, e_wready);
    if (e_wready != 2'b00) chk("m_wdata", m_wdata, s_wdata[owner]);
    chk("req_rvalid", req_rvalid, e_rvalid);
    if (e_rvalid != 2'b00) chk("req_rdata", req_rdata, s_rdata);
    if (req_ready != 2'b00) ready_pulses++;
    if (req_rvalid == 2'b01) rvalid0_cycles++;
    if (req_wready == 2'b10) wready1_cycles++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    drive();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || cq0.size() > 0 || cq1.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", {63'd0, busy || cq0.size() > 0 || cq1.size() > 0}, 64'd0);
  endtask

  function automatic cmd_t mk(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] l);
    cmd_t c;
    c.addr = a;
    c.we = w;
    c.len = l;
    return c;
  endfunction

  initial begin
    logic [DW-1:0] exp_rd [4];
    int exp_gl [4];
    int b0, w1, n;
    cmd_t c;

    exp_rd[0] = 16'h00A0; exp_rd[1] = 16'h00A1; exp_rd[2] = 16'h00A2; exp_rd[3] = 16'h00A3;
    wr_beats[0] = 0; wr_beats[1] = 0; rd_beats[0] = 0; rd_beats[1] = 0;

    // Reset and idle values.
    rst_drive = 1;
    drive();
    cycle();
    cycle();
    rst_drive = 0;
    cycle();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_addr", m_addr, 24'h0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_m_len", m_len, 4'h0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_req_wready", req_wready, 2'b00);
    chk("rst_req_rvalid", req_rvalid, 2'b00);

    // Single 4-beat read by requester 0.
    rd_log0.delete(); grant_log.delete(); rvalid0_cycles = 0;
    rd_seq = {16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    rvalid_pct = 60;
    cq0.push_back(mk(24'h000100, 1'b0, 4'd3));
    wait_idle(200);
    cycle();
    chk("rd_gnt_after", gnt, 2'b00);
    chk("rd_beats", rd_log0.size(), 4);
    for (int i = 0; i < 4 && i < rd_log0.size(); i++) chk("rd_data", rd_log0[i], exp_rd[i]);
    chk("rd_rvalid_cycles", rvalid0_cycles, 4);
    chk("rd_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("rd_grant0", grant_log[0], 0);

    // Two-beat write by requester 1 with a stalling controller.
    wready1_cycles = 0;
    w1 = wr_beats[1];
    wready_pct = 40;
    cq1.push_back(mk(24'h001000, 1'b1, 4'd1));
    wait_idle(200);
    chk("wr_beats", wr_beats[1] - w1, 2);
    chk("wr_wready_cycles", wready1_cycles, 2);

    // Repeated ties: two short reads queued at each requester.
    grant_log.delete();
    mready_pct = 100; wready_pct = 100; rvalid_pct = 100;
`ifdef SDRAM_ARB_RR_EN
    exp_gl[0] = 0; exp_gl[1] = 1; exp_gl[2] = 0; exp_gl[3] = 1;
`else
    exp_gl[0] = 0; exp_gl[1] = 0; exp_gl[2] = 1; exp_gl[3] = 1;
`endif
    for (int i = 0; i < 2; i++) begin
      cq0.push_back(mk(24'h000200 + 24'(i), 1'b0, 4'd0));
      cq1.push_back(mk(24'h000300 + 24'(i), 1'b0, 4'd0));
    end
    wait_idle(200);
    chk("tie_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("tie_order", grant_log[i], exp_gl[i]);

    // Controller holds off the command for several cycles.
    ready_pulses = 0;
    mready_pct = 0;
    drop_ok = 1;
    cq0.push_back(mk(24'h0ABCDE, 1'b0, 4'd0));
    for (int i = 0; i < 7; i++) cycle();
    mready_pct = 100;
    wait_idle(200);
    drop_ok = 0;
    chk("cmd_ready_pulses", ready_pulses, 1);

    // Reset in the middle of an 8-beat read, then a normal write.
    cq0.push_back(mk(24'h004000, 1'b0, 4'd7));
    b0 = rd_beats[0];
    n = 0;
    while (rd_beats[0] - b0 < 3 && n < 100) begin
      cycle();
      n++;
    end
    chk("mid_rst_reached", rd_beats[0] - b0, 3);
    rst_drive = 1;
    cycle();
    rst_drive = 0;
    cycle();
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    w1 = wr_beats[1];
    cq1.push_back(mk(24'h005000, 1'b1, 4'd2));
    wait_idle(200);
    chk("post_rst_wr_beats", wr_beats[1] - w1, 3);

    // Longest burst.
    w1 = wr_beats[1];
    wready_pct = 70;
    cq1.push_back(mk(24'h006000, 1'b1, 4'd15));
    wait_idle(400);
    cycle();
    chk("len15_beats", wr_beats[1] - w1, 16);
    chk("len15_gnt_after", gnt, 2'b00);

    // Random traffic with occasional resets.
    drop_ok = 1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        mready_pct = $urandom_range(20, 100);
        wready_pct = $urandom_range(20, 100);
        rvalid_pct = $urandom_range(20, 100);
      end
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          c.addr = AW'($urandom);
          c.we = 1'($urandom);
          c.len = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 3));
          if (r == 0 && cq0.size() < 3) cq0.push_back(c);
          if (r == 1 && cq1.size() < 3) cq1.push_back(c);
        end
      end
      rst_drive = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst_drive = 0;
    drop_ok = 0;
    wait_idle(3000);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
